// File: rtl/downsample_pkg.sv
`default_nettype none
// ============================================================================
// Module      : downsample_pkg
// Description : Shared types, constants and helpers for the receive-side
//               downsampler (pick / integrate-and-dump decimator).
// Revision    : 1.0 - initial release
// ============================================================================
package downsample_pkg;

  // Pending timing-recovery request held by the window controller.
  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_ADV  = 2'b01,
    REQ_RET  = 2'b10
  } req_e;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  // Decimation factor from the two sample rates.
  function automatic int calc_n(input int in_rate, input int out_rate);
    return in_rate / out_rate;
  endfunction

  // Accumulator width: room for N+1 full-scale samples (a retarded window).
  function automatic int calc_acc_width(input int symbol_width, input int n);
    return symbol_width + clog2(n + 1);
  endfunction

  // Values for the default configuration (6 MHz in, 3 MHz out, 16-bit).
  localparam int C_DEF_N         = calc_n(6_000_000, 3_000_000);
  localparam int C_DEF_ACC_WIDTH = calc_acc_width(16, C_DEF_N);

endpackage : downsample_pkg
`default_nettype wire

// File: rtl/downsample_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : downsample_window_ctrl
// Description : Decimation window counter with +/-1 sample phase slip.
//               Produces the end-of-window dump strobe and tracks a single
//               pending advance/retard request.
// Revision    : 1.0 - initial release
// ============================================================================
module downsample_window_ctrl
  import downsample_pkg::*;
#(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,          // asynchronous, active low
  input  logic en,
  input  logic new_sample,
  input  logic phase_adv,
  input  logic phase_ret,
  output logic dump,
  output logic adj_pending
);

  // Counter must reach N (last index of an N+1 window) and hold length N+1.
  localparam int CW = clog2(N + 2);
  localparam logic [CW-1:0] C_LEN_NOM = CW'(N);
  localparam logic [CW-1:0] C_LEN_ADV = CW'(N - 1);
  localparam logic [CW-1:0] C_LEN_RET = CW'(N + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_len;
  req_e          r_pend;

  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_len_nxt;
  req_e          w_pend_nxt;
  req_e          w_new_req;
  req_e          w_req_eff;
  logic          w_accept;
  logic          w_last;

  assign w_accept    = en & new_sample;
  assign w_last      = (r_cnt == (r_len - 1'b1));
  assign dump        = w_accept & w_last;
  assign adj_pending = (r_pend != REQ_NONE);

  // Decode this cycle's request; simultaneous advance+retard cancels out.
  always_comb begin
    w_new_req = REQ_NONE;
    if (en && phase_adv && !phase_ret) w_new_req = REQ_ADV;
    if (en && phase_ret && !phase_adv) w_new_req = REQ_RET;
  end

  // A held request wins; otherwise a fresh request can apply at a same-cycle dump.
  assign w_req_eff = (r_pend != REQ_NONE) ? r_pend : w_new_req;

  // Next-state: count accepted samples, reload length and consume request at dump.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_len_nxt  = r_len;
    w_pend_nxt = r_pend;
    if (r_pend == REQ_NONE) w_pend_nxt = w_new_req;
    if (w_accept) begin
      if (w_last) begin
        w_cnt_nxt = '0;
        case (w_req_eff)
          REQ_ADV: begin
            w_len_nxt  = C_LEN_ADV;
            w_pend_nxt = REQ_NONE;
          end
          REQ_RET: begin
            w_len_nxt  = C_LEN_RET;
            w_pend_nxt = REQ_NONE;
          end
          default: w_len_nxt = C_LEN_NOM;
        endcase
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  // State registers; everything naturally holds while en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_len  <= C_LEN_NOM;
      r_pend <= REQ_NONE;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_len  <= w_len_nxt;
      r_pend <= w_pend_nxt;
    end
  end

endmodule : downsample_window_ctrl
`default_nettype wire

// File: rtl/downsample.sv
`default_nettype none
// ============================================================================
// Module      : downsample
// Description : Receive-side decimator by N = IN_RATE/OUT_RATE. Outputs the
//               last sample (pick) or the sum (integrate-and-dump) of each
//               window; window boundaries slip via phase_adv/phase_ret.
// Revision    : 1.0 - initial release
// ============================================================================
module downsample
  import downsample_pkg::*;
#(
  parameter  int IN_RATE      = 6_000_000,
  parameter  int OUT_RATE     = 3_000_000,
  parameter  int SYMBOL_WIDTH = 16,
  parameter  int INTEGRATE    = 0,
  localparam int N            = calc_n(IN_RATE, OUT_RATE),
  localparam int ACC_WIDTH    = calc_acc_width(SYMBOL_WIDTH, N)
) (
  input  logic                           clk,
  input  logic                           rst,          // asynchronous, active low
  input  logic                           en,
  input  logic                           new_sample,
  input  logic signed [SYMBOL_WIDTH-1:0] i_sample,
  input  logic                           phase_adv,
  input  logic                           phase_ret,
  output logic signed [ACC_WIDTH-1:0]    o_sample,
  output logic                           o_valid,
  output logic                           o_adj_pending
);

  logic                        w_dump;
  logic                        w_accept;
  logic signed [ACC_WIDTH-1:0] w_ext;
  logic signed [ACC_WIDTH-1:0] w_dump_val;

  assign w_accept = en & new_sample;
  assign w_ext    = ACC_WIDTH'(i_sample);

  downsample_window_ctrl #(
    .N (N)
  ) u_window_ctrl (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .new_sample  (new_sample),
    .phase_adv   (phase_adv),
    .phase_ret   (phase_ret),
    .dump        (w_dump),
    .adj_pending (o_adj_pending)
  );

  generate
    if (INTEGRATE != 0) begin : g_integrate
      logic signed [ACC_WIDTH-1:0] r_acc;

      // Running window sum; cleared when the window is dumped.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_acc <= '0;
        end else if (w_dump) begin
          r_acc <= '0;
        end else if (w_accept) begin
          r_acc <= r_acc + w_ext;
        end
      end

      assign w_dump_val = r_acc + w_ext;
    end else begin : g_pick
      assign w_dump_val = w_ext;
    end
  endgenerate

  // Output register: load at dump, hold otherwise; o_valid is a one-cycle strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_sample <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= w_dump;
      if (w_dump) o_sample <= w_dump_val;
    end
  end

endmodule : downsample
`default_nettype wire

// File: tb/tb_downsample.sv
`default_nettype none
// ============================================================================
// Module      : tb_downsample
// Description : Scoreboard bench for downsample, pick and integrate instances
//               driven with identical directed stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_downsample;

  logic               clk;
  logic               rst;
  logic               en;
  logic               new_sample;
  logic signed [15:0] i_sample;
  logic               phase_adv;
  logic               phase_ret;

  logic signed [17:0] p_sample;
  logic               p_valid;
  logic               p_pend;
  logic signed [17:0] s_sample;
  logic               s_valid;
  logic               s_pend;

  int checks   = 0;
  int failures = 0;
  int q_pick[$];
  int q_int[$];

  downsample #(
    .IN_RATE(6_000_000), .OUT_RATE(3_000_000), .SYMBOL_WIDTH(16), .INTEGRATE(0)
  ) dut_pick (
    .clk(clk), .rst(rst), .en(en), .new_sample(new_sample), .i_sample(i_sample),
    .phase_adv(phase_adv), .phase_ret(phase_ret),
    .o_sample(p_sample), .o_valid(p_valid), .o_adj_pending(p_pend)
  );

  downsample #(
    .IN_RATE(6_000_000), .OUT_RATE(3_000_000), .SYMBOL_WIDTH(16), .INTEGRATE(1)
  ) dut_int (
    .clk(clk), .rst(rst), .en(en), .new_sample(new_sample), .i_sample(i_sample),
    .phase_adv(phase_adv), .phase_ret(phase_ret),
    .o_sample(s_sample), .o_valid(s_valid), .o_adj_pending(s_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every o_valid pops the next expected value for that instance.
  always @(negedge clk) begin
    if (rst) begin
      if (p_valid) begin
        if (q_pick.size() == 0) check("pick_unexpected_valid", 1, 0);
        else check("pick_dump", int'(p_sample), q_pick.pop_front());
      end
      if (s_valid) begin
        if (q_int.size() == 0) check("int_unexpected_valid", 1, 0);
        else check("int_dump", int'(s_sample), q_int.pop_front());
      end
    end
  end

  task automatic send(input int s, input logic adv, input logic ret);
    @(negedge clk);
    en         = 1'b1;
    new_sample = 1'b1;
    i_sample   = 16'(s);
    phase_adv  = adv;
    phase_ret  = ret;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      new_sample = 1'b0;
      phase_adv  = 1'b0;
      phase_ret  = 1'b0;
      en         = 1'b1;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    new_sample = 1'b0;
    phase_adv  = 1'b0;
    phase_ret  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain(input string name);
    check({name, "_pick_drained"}, q_pick.size(), 0);
    check({name, "_int_drained"},  q_int.size(),  0);
    q_pick.delete();
    q_int.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b0; new_sample = 1'b0; i_sample = '0;
    phase_adv = 1'b0; phase_ret = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pick_sample", int'(p_sample), 0);
    check("rst_pick_valid",  int'(p_valid),  0);
    check("rst_pick_pend",   int'(p_pend),   0);
    check("rst_int_sample",  int'(s_sample), 0);
    rst = 1'b1;

    // Basic decimation by 2.
    q_pick = '{2, 4}; q_int = '{3, 7};
    send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(4, 0, 0);
    idle(4);
    check("pick_hold", int'(p_sample), 4);
    check("int_hold",  int'(s_sample), 7);
    drain("basic");

    // Full-scale sums must not wrap in 18 bits.
    reset_dut();
    q_pick = '{-300, 32767}; q_int = '{-200, 65534};
    send(100, 0, 0); send(-300, 0, 0); send(32767, 0, 0); send(32767, 0, 0);
    idle(4);
    drain("fullscale");

    // Advance: window lengths 2,1,2,2.
    reset_dut();
    q_pick = '{2, 3, 5, 7}; q_int = '{3, 3, 9, 13};
    send(1, 1, 0); idle(1);
    check("adv_pending", int'(p_pend), 1);
    for (int s = 2; s <= 7; s++) send(s, 0, 0);
    idle(4);
    check("adv_cleared", int'(p_pend), 0);
    drain("adv");

    // Retard: window lengths 2,3,2.
    reset_dut();
    q_pick = '{2, 5, 7}; q_int = '{3, 12, 13};
    send(1, 0, 1); idle(1);
    check("ret_pending", int'(s_pend), 1);
    for (int s = 2; s <= 7; s++) send(s, 0, 0);
    idle(4);
    check("ret_cleared", int'(s_pend), 0);
    drain("ret");

    // Simultaneous requests are ignored.
    reset_dut();
    q_pick = '{2, 4, 6}; q_int = '{3, 7, 11};
    send(1, 1, 1); idle(1);
    check("both_pending", int'(p_pend), 0);
    for (int s = 2; s <= 6; s++) send(s, 0, 0);
    idle(4);
    drain("both");

    // Retard arriving while advance is pending is dropped.
    reset_dut();
    q_pick = '{2, 3, 5, 7}; q_int = '{3, 3, 9, 13};
    send(1, 1, 0); send(2, 0, 1);
    for (int s = 3; s <= 7; s++) send(s, 0, 0);
    idle(4);
    check("advret_pending", int'(p_pend), 0);
    drain("advret");

    // en low mid-window: strobes and requests in the gap are ignored.
    reset_dut();
    q_pick = '{20}; q_int = '{30};
    send(10, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en = 1'b0; new_sample = 1'b1; i_sample = 16'sd99; phase_adv = 1'b1;
    end
    send(20, 0, 0);
    idle(4);
    check("enlow_pending", int'(p_pend), 0);
    drain("enlow");

    // Asynchronous reset mid-window discards the partial window.
    reset_dut();
    q_pick = '{4}; q_int = '{7};
    send(3, 0, 0); send(4, 0, 0); send(1, 0, 0); idle(1);
    #2 rst = 1'b0;
    #1;
    check("async_pick_sample", int'(p_sample), 0);
    check("async_int_sample",  int'(s_sample), 0);
    check("async_int_valid",   int'(s_valid),  0);
    @(negedge clk);
    rst = 1'b1;
    q_pick.push_back(8); q_int.push_back(15);
    send(7, 0, 0); send(8, 0, 0);
    idle(4);
    drain("async");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_downsample
`default_nettype wire
